control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/ctrl_wait_timer.sv | 30 +++
 rtl/control_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state codes, instruction field positions and output bundle
package ctrl_pkg;

    localparam logic [5:0] S_RST    = 6'd0;
    localparam logic [5:0] S_FETCH  = 6'd1;
    localparam logic [5:0] S_IFREQ  = 6'd2;
    localparam logic [5:0] S_IFWAIT = 6'd3;
    localparam logic [5:0] S_DECODE = 6'd4;
    localparam logic [5:0] S_DPI    = 6'd5;
    localparam logic [5:0] S_DPR    = 6'd7;
    localparam logic [5:0] S_BR     = 6'd8;
    localparam logic [5:0] S_BL     = 6'd10;
    localparam logic [5:0] S_UNDEF  = 6'd12;
    localparam logic [5:0] S_LSADDR = 6'd33;
    localparam logic [5:0] S_LSRD   = 6'd34;
    localparam logic [5:0] S_LSWR   = 6'd41;
    localparam logic [5:0] S_LSWB   = 6'd36;
    localparam logic [5:0] S_ABORT  = 6'd63;

    // ir[27:25] instruction classes
    localparam logic [2:0] CLS_DPR    = 3'b000;
    localparam logic [2:0] CLS_DPI    = 3'b001;
    localparam logic [2:0] CLS_LS_IMM = 3'b010;
    localparam logic [2:0] CLS_LS_REG = 3'b011;
    localparam logic [2:0] CLS_BRANCH = 3'b101;

    localparam int IR_CLS_HI = 27;
    localparam int IR_CLS_LO = 25;
    localparam int IR_P      = 24;
    localparam int IR_LINK   = 24;
    localparam int IR_U      = 23;
    localparam int IR_B      = 22;
    localparam int IR_WB     = 21;
    localparam int IR_L      = 20;

    typedef struct packed {
        logic ld_mar;
        logic ld_ir;
        logic ld_pc;
        logic ld_rf;
        logic mem_en;
        logic mem_rw;
        logic mem_byte;
        logic abort;
        logic undef;
    } ctrl_out_t;

endpackage

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - memory wait counter with bus-timeout compare
module ctrl_wait_timer
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       active,
    input  logic       moc,
    output logic [7:0] count,
    output logic       expired
);

    localparam logic [7:0] LAST = 8'(WAIT_MAX - 1);

    // Every wait state is entered from a non-wait state, so clearing while idle covers entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (!active || moc) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign expired = active && !moc && (count == LAST);

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore instruction-sequencing FSM with memory wait timeout
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int STATE_W  = 7,
    parameter int IR_W     = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic [IR_W-1:0]    ir,
    input  logic               moc,
    input  logic               cond,
    output logic [STATE_W-1:0] state,
    output logic               ld_mar,
    output logic               ld_ir,
    output logic               ld_pc,
    output logic               ld_rf,
    output logic               mem_en,
    output logic               mem_rw,
    output logic               mem_byte,
    output logic               abort,
    output logic               undef
);

    localparam logic [STATE_W-1:0] ST_RST    = STATE_W'(S_RST);
    localparam logic [STATE_W-1:0] ST_FETCH  = STATE_W'(S_FETCH);
    localparam logic [STATE_W-1:0] ST_IFREQ  = STATE_W'(S_IFREQ);
    localparam logic [STATE_W-1:0] ST_IFWAIT = STATE_W'(S_IFWAIT);
    localparam logic [STATE_W-1:0] ST_DECODE = STATE_W'(S_DECODE);
    localparam logic [STATE_W-1:0] ST_DPI    = STATE_W'(S_DPI);
    localparam logic [STATE_W-1:0] ST_DPR    = STATE_W'(S_DPR);
    localparam logic [STATE_W-1:0] ST_BR     = STATE_W'(S_BR);
    localparam logic [STATE_W-1:0] ST_BL     = STATE_W'(S_BL);
    localparam logic [STATE_W-1:0] ST_UNDEF  = STATE_W'(S_UNDEF);
    localparam logic [STATE_W-1:0] ST_LSADDR = STATE_W'(S_LSADDR);
    localparam logic [STATE_W-1:0] ST_LSRD   = STATE_W'(S_LSRD);
    localparam logic [STATE_W-1:0] ST_LSWR   = STATE_W'(S_LSWR);
    localparam logic [STATE_W-1:0] ST_LSWB   = STATE_W'(S_LSWB);
    localparam logic [STATE_W-1:0] ST_ABORT  = STATE_W'(S_ABORT);

    logic [STATE_W-1:0] next_state;
    logic               in_wait;
    logic               expired;
    logic [7:0]         wait_count;
    logic [2:0]         cls;
    logic               writeback;
    ctrl_out_t          outs;
    logic               unused_bits;

    assign cls         = ir[IR_CLS_HI:IR_CLS_LO];
    // Post-indexed (P=0) always writes back; pre-indexed only when W is set.
    assign writeback   = !ir[IR_P] || ir[IR_WB];
    assign in_wait     = (state == ST_IFWAIT) || (state == ST_LSRD) || (state == ST_LSWR);
    assign unused_bits = ^{ir, wait_count};

    ctrl_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk    (CLK),
        .resetn (CLR),
        .active (in_wait),
        .moc    (moc),
        .count  (wait_count),
        .expired(expired)
    );

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state <= ST_RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = ST_RST;
        case (state)
            ST_RST:    next_state = ST_FETCH;
            ST_FETCH:  next_state = ST_IFREQ;
            ST_IFREQ:  next_state = ST_IFWAIT;
            ST_IFWAIT: begin
                if (moc)          next_state = ST_DECODE;
                else if (expired) next_state = ST_ABORT;
                else              next_state = ST_IFWAIT;
            end
            ST_DECODE: begin
                if (!cond) begin
                    next_state = ST_FETCH;
                end else begin
                    case (cls)
                        CLS_DPR:    next_state = ST_DPR;
                        CLS_DPI:    next_state = ST_DPI;
                        CLS_LS_IMM: next_state = ST_LSADDR;
                        CLS_LS_REG: next_state = ST_LSADDR;
                        CLS_BRANCH: next_state = ir[IR_LINK] ? ST_BL : ST_BR;
                        default:    next_state = ST_UNDEF;
                    endcase
                end
            end
            ST_DPI:    next_state = ST_FETCH;
            ST_DPR:    next_state = ST_FETCH;
            ST_UNDEF:  next_state = ST_FETCH;
            ST_BL:     next_state = ST_BR;
            ST_BR:     next_state = ST_FETCH;
            ST_LSADDR: next_state = ir[IR_L] ? ST_LSRD : ST_LSWR;
            ST_LSRD, ST_LSWR: begin
                if (moc)          next_state = writeback ? ST_LSWB : ST_FETCH;
                else if (expired) next_state = ST_ABORT;
                else              next_state = state;
            end
            ST_LSWB:   next_state = ST_FETCH;
            ST_ABORT:  next_state = ST_ABORT;
            default:   next_state = ST_RST;
        endcase
    end

    // ld_rf is held through the whole read so the final data beat is always captured.
    always_comb begin
        outs = '0;
        case (state)
            ST_FETCH: begin
                outs.ld_mar = 1'b1;
                outs.ld_pc  = 1'b1;
            end
            ST_IFWAIT: begin
                outs.mem_en = 1'b1;
                outs.mem_rw = 1'b1;
            end
            ST_DECODE: outs.ld_ir = 1'b1;
            ST_DPI:    outs.ld_rf = 1'b1;
            ST_DPR:    outs.ld_rf = 1'b1;
            ST_BL:     outs.ld_rf = 1'b1;
            ST_BR:     outs.ld_pc = 1'b1;
            ST_UNDEF:  outs.undef = 1'b1;
            ST_LSADDR: outs.ld_mar = 1'b1;
            ST_LSRD: begin
                outs.mem_en   = 1'b1;
                outs.mem_rw   = ir[IR_L];
                outs.mem_byte = ir[IR_B];
                outs.ld_rf    = 1'b1;
            end
            ST_LSWR: begin
                outs.mem_en   = 1'b1;
                outs.mem_rw   = ir[IR_L];
                outs.mem_byte = ir[IR_B];
            end
            ST_LSWB:   outs.ld_rf = 1'b1;
            ST_ABORT:  outs.abort = 1'b1;
            default:   outs = '0;
        endcase
    end

    assign ld_mar   = outs.ld_mar;
    assign ld_ir    = outs.ld_ir;
    assign ld_pc    = outs.ld_pc;
    assign ld_rf    = outs.ld_rf;
    assign mem_en   = outs.mem_en;
    assign mem_rw   = outs.mem_rw;
    assign mem_byte = outs.mem_byte;
    assign abort    = outs.abort;
    assign undef    = outs.undef;

endmodule
